r_ctr_ramp_sequencer: RTL

Multi-channel, parametrised successor to the combinational resistor-code decoder. It holds a registered 5-bit resistor program code per channel and accepts retarget requests through a valid/ready handshake. It steps the code one LSB at a time with a programmable dwell, so the HSNR/HDR feedback resistors never jump more than one step, and drives the decoded 8-bit `R_ctr` word for every channel from registers. It sits between the register/config block and the analog front-end resistor switch banks.

---
 rtl/r_ctr_ramp_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/r_ctr_ramp_sequencer.sv
// ============================================================================
// Module   : r_ctr_ramp_sequencer
// Purpose  : Per-channel resistor-code ramp sequencer with registered R_ctr decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r_ctr_ramp_sequencer #(
    parameter int N_CH  = 4,
    parameter int DWELL = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CH_W-1:0]     req_ch,
    input  logic [4:0]          req_code,
    output logic                busy,
    output logic                done,
    output logic [N_CH*5-1:0]   cur_code,
    output logic [N_CH*8-1:0]   R_ctr
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [4:0]       c_code_off = 5'd31;
    localparam logic [CNT_W-1:0] c_dwell_ld = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CH_W-1:0]        r_ch;
    logic [4:0]             r_tgt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done;
    logic [N_CH-1:0][4:0]   r_cur;
    logic [N_CH-1:0][7:0]   r_rctr;

    logic [4:0]             w_cur;
    logic [4:0]             w_next;
    logic                   w_wr;
    logic                   w_direct;
    logic                   w_ch_ok;
    logic [4:0]             w_req_norm;

    function automatic logic [3:0] nib(input logic [1:0] s);
        case (s)
            2'd0:    nib = 4'b1110;
            2'd1:    nib = 4'b0101;
            2'd2:    nib = 4'b1101;
            default: nib = 4'b1011;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [4:0] c);
        decode = c[4] ? 8'hFF : {nib(c[1:0]), nib(c[3:2])};
    endfunction

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign cur_code   = r_cur;
    assign R_ctr      = r_rctr;
    assign w_ch_ok    = (32'(req_ch) < N_CH);
    assign w_req_norm = req_code[4] ? c_code_off : req_code;

    always_comb begin
        w_cur = c_code_off;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == CH_W'(i)) w_cur = r_cur[i];
        end
    end

    // OFF on either side moves in one jump; otherwise a single LSB toward target.
    assign w_direct = w_cur[4] | r_tgt[4];
    assign w_wr     = (r_state == S_STEP) && (w_cur != r_tgt);
    assign w_next   = w_direct ? r_tgt :
                      (r_tgt > w_cur) ? (w_cur + 5'd1) : (w_cur - 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_tgt   <= c_code_off;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_cur[i]  <= c_code_off;
                r_rctr[i] <= 8'hFF;
            end
        end else begin
            r_done <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (w_wr && (r_ch == CH_W'(i))) begin
                    r_cur[i]  <= w_next;
                    r_rctr[i] <= decode(w_next);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ch  <= req_ch;
                        r_tgt <= w_req_norm;
                        // Out-of-range channels are consumed without effect.
                        if (w_ch_ok) r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    if ((w_cur == r_tgt) || w_direct) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= c_dwell_ld;
                        r_state <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (r_cnt == '0) r_state <= S_STEP;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
